regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter REG_COUNT, default 32, number of architectural registers (power of two, >= 4).
REQ-002 The block SHALL have parameter WIDTH, default 32, data width in bits.
REQ-003 The block SHALL have parameter IDX_WIDTH, default 5, register index width, equal to log2(REG_COUNT).
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port: clk  in  1  rising-edge clock for all state.
REQ-006 Port: rst  in  1  synchronous active-high reset.
REQ-007 Port: src1, src2  in  IDX_WIDTH  read-port register indices.
REQ-008 Port: rd_data1, rd_data2  out  WIDTH  read data (combinational).
REQ-009 Port: rd_busy1, rd_busy2  out  1  source register has a pending load.
REQ-010 Port: wr_en0, dest0, wr_data0  in  1/IDX_WIDTH/WIDTH  write port 0 (ALU writeback).
REQ-011 Port: wr_en1, dest1, wr_data1  in  1/IDX_WIDTH/WIDTH  write port 1 (load writeback); clears scoreboard.
REQ-012 Port: rsv_en, rsv_dest  in  1/IDX_WIDTH  reserve dest for an outstanding load (sets busy).
REQ-013 Port: ready  out  1  high when the clear sweep is done and the file accepts traffic.

Function
REQ-014 The block SHALL implement a two-state FSM, CLEAR and RUN; ready = 1 only in RUN.
REQ-015 In CLEAR with rst low, the block SHALL write zero to regs[cnt] and increment cnt each cycle, starting at cnt = 1; after the cycle that writes index REG_COUNT-1 the FSM SHALL enter RUN.
REQ-016 ready SHALL rise exactly REG_COUNT-1 cycles after the first rising edge with rst low (31 for defaults).
REQ-017 While ready = 0, rd_data1/2 SHALL be 0, rd_busy1/2 SHALL be 0, and wr_en0, wr_en1 and rsv_en SHALL be ignored.
REQ-018 Index 0 SHALL read as zero, SHALL never be written, and SHALL never be busy.
REQ-019 In RUN, a write on port k SHALL update regs[destk] at the rising edge when wr_enk = 1 and destk != 0.
REQ-020 When both ports write the same nonzero dest in one cycle, port 1 SHALL win.
REQ-021 Reads SHALL bypass same-cycle writes: if wr_enk = 1 and destk == srcN != 0, rd_dataN = wr_datak, with port 1 taking priority over port 0, then stored contents.
REQ-022 The scoreboard SHALL hold busy[REG_COUNT-1:1], all cleared to 0 by reset.
REQ-023 rsv_en = 1 with rsv_dest != 0 SHALL set busy[rsv_dest] at the edge.
REQ-024 wr_en1 = 1 with dest1 != 0 SHALL clear busy[dest1] at the edge.
REQ-025 wr_en0 SHALL NOT affect busy.
REQ-026 When set and clear hit the same register in one cycle, set SHALL win (a new reservation overrides the old completion).
REQ-027 rd_busyN SHALL equal busy[srcN] & ~(wr_en1 & dest1 == srcN), i.e. a completing load is bypassed and not reported busy.
REQ-028 Reserving an already-busy register SHALL leave it busy; clearing a non-busy register SHALL be a no-op.

Reset
REQ-029 rst = 1 at an edge SHALL force CLEAR, cnt = 1, ready = 0 and all busy = 0, from any state, including mid-sweep and RUN.
REQ-030 rst SHALL NOT zero the storage array directly; zeroing is done only by the sweep.

Verification
REQ-031 Reset release: rst high for 2 cycles, then low -> ready = 0 for 31 cycles, then 1; every register reads 0.
REQ-032 Write/bypass: wr_en0 = 1, dest0 = 5, wr_data0 = 0xDEADBEEF, src1 = 5 in the same cycle -> rd_data1 = 0xDEADBEEF that cycle and the next.
REQ-033 Port conflict: both ports write reg 7 (0x11, 0x22) -> reg 7 reads 0x22; write to reg 0 -> reads 0.
REQ-034 Scoreboard: rsv reg 9 -> rd_busy1 = 1 (src1 = 9); wr_en1 to reg 9 -> rd_busy1 = 0 in that cycle, data bypassed; same-cycle rsv and wr_en1 on reg 9 -> busy stays 1.
REQ-035 Mid-sweep reset: assert rst at sweep cycle 10 -> ready stays 0 and the full 31-cycle sweep restarts; writes issued during the sweep are lost.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with load scoreboard and post-reset zeroing sweep; reads and busy are combinational with same-cycle write bypass.
// Writes/reservations take effect at the edge; no backpressure, but all traffic is dropped until ready rises after the sweep.
module regfile_sb #(
    parameter int REG_COUNT = 32,
    parameter int WIDTH     = 32,
    parameter int IDX_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_WIDTH-1:0] src1,
    input  logic [IDX_WIDTH-1:0] src2,
    output logic [WIDTH-1:0]     rd_data1,
    output logic [WIDTH-1:0]     rd_data2,
    output logic                 rd_busy1,
    output logic                 rd_busy2,
    input  logic                 wr_en0,
    input  logic [IDX_WIDTH-1:0] dest0,
    input  logic [WIDTH-1:0]     wr_data0,
    input  logic                 wr_en1,
    input  logic [IDX_WIDTH-1:0] dest1,
    input  logic [WIDTH-1:0]     wr_data1,
    input  logic                 rsv_en,
    input  logic [IDX_WIDTH-1:0] rsv_dest,
    output logic                 ready
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t               state;
    logic [IDX_WIDTH-1:0] cnt;
    logic [WIDTH-1:0]     regs [REG_COUNT];
    logic [REG_COUNT-1:0] busy;
    logic [REG_COUNT-1:0] busy_nxt;
    logic                 we0;
    logic                 we1;
    logic                 rsv;

    assign we0 = ready & wr_en0 & (dest0 != '0);
    assign we1 = ready & wr_en1 & (dest1 != '0);
    assign rsv = ready & rsv_en & (rsv_dest != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= IDX_WIDTH'(1);
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + IDX_WIDTH'(1);
                    if (cnt == IDX_WIDTH'(REG_COUNT - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                default: ready <= 1'b1;
            endcase
        end
    end

    // Storage is never reset; the sweep is the only thing that zeroes it.
    // Index 0 is never written and is forced to zero on the read side.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[cnt] <= '0;
            end else begin
                if (we0) regs[dest0] <= wr_data0;
                if (we1) regs[dest1] <= wr_data1;
            end
        end
    end

    // Set is applied after clear so a fresh reservation beats a completing load.
    always_comb begin
        busy_nxt = busy;
        if (we1) busy_nxt[dest1] = 1'b0;
        if (rsv) busy_nxt[rsv_dest] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign rd_data1 = (!ready || src1 == '0)  ? '0       :
                      (we1 && dest1 == src1)  ? wr_data1 :
                      (we0 && dest0 == src1)  ? wr_data0 :
                                                regs[src1];
    assign rd_data2 = (!ready || src2 == '0)  ? '0       :
                      (we1 && dest1 == src2)  ? wr_data1 :
                      (we0 && dest0 == src2)  ? wr_data0 :
                                                regs[src2];

    assign rd_busy1 = ready & busy[src1] & ~(we1 & (dest1 == src1));
    assign rd_busy2 = ready & busy[src2] & ~(we1 & (dest2_match(src2)));

    function automatic logic dest2_match(input logic [IDX_WIDTH-1:0] s);
        return dest1 == s;
    endfunction

endmodule
